// File: rtl/rsa_result_reader.sv
// rsa_result_reader: reads stored RSA results back from BRAM in address order and
// streams them out through a 4-word queue that absorbs read latency and backpressure.
module rsa_result_reader #(
    parameter int ADDR_bw      = 13,
    parameter int BRAM_DATA_bw = 32,
    parameter int MAX_DATA_NUM = 128,
    parameter int RD_LATENCY   = 2
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    wr_tick,
    input  logic                    rd_enable,
    input  logic                    clr,
    output logic [ADDR_bw-1:0]      BRAM_rd_addr,
    output logic                    BRAM_rd_en,
    input  logic [BRAM_DATA_bw-1:0] BRAM_rd_dout,
    output logic [BRAM_DATA_bw-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [ADDR_bw:0]        avail_cnt,
    output logic                    overflow
);

    // state | meaning
    // IDLE  | reader off, nothing outstanding
    // RUN   | rd_enable high, reads issued while results and queue space exist
    // DRAIN | rd_enable low, in-flight words still captured and delivered
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int                 QDEPTH    = 4;
    localparam logic [ADDR_bw:0]   AVAIL_MAX = (ADDR_bw+1)'(MAX_DATA_NUM);
    localparam logic [ADDR_bw-1:0] ADDR_LAST = ADDR_bw'(MAX_DATA_NUM - 1);

    state_t                  state;
    logic [ADDR_bw-1:0]      rd_ptr;
    logic [RD_LATENCY-1:0]   fl_vld;
    logic [RD_LATENCY-1:0]   fl_last;
    logic [BRAM_DATA_bw-1:0] q_data [QDEPTH];
    logic [QDEPTH-1:0]       q_last;
    logic [2:0]              q_cnt;

    logic                    push;
    logic                    pop;
    logic                    ovf_evt;
    logic                    issue_nxt;
    logic [RD_LATENCY-1:0]   fl_vld_nxt;
    logic [RD_LATENCY-1:0]   fl_last_nxt;
    logic [2:0]              fl_cnt_nxt;
    logic [2:0]              q_cnt_nxt;
    logic [1:0]              wr_idx;
    logic [ADDR_bw:0]        avail_nxt;

    assign out_valid = (q_cnt != 3'd0);
    assign out_data  = q_data[0];
    assign out_last  = q_last[0];
    assign push      = fl_vld[RD_LATENCY-1];
    assign pop       = out_valid && out_ready;

    // Issue is decided one cycle ahead from next-cycle occupancy so BRAM_rd_en can be registered.
    always_comb begin
        fl_vld_nxt     = '0;
        fl_last_nxt    = '0;
        fl_vld_nxt[0]  = BRAM_rd_en;
        fl_last_nxt[0] = BRAM_rd_en && (BRAM_rd_addr == ADDR_LAST);
        for (int i = 1; i < RD_LATENCY; i++) begin
            fl_vld_nxt[i]  = fl_vld[i-1];
            fl_last_nxt[i] = fl_last[i-1];
        end
        fl_cnt_nxt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            fl_cnt_nxt = fl_cnt_nxt + 3'(fl_vld_nxt[i]);
        end

        q_cnt_nxt = q_cnt + 3'(push) - 3'(pop);
        wr_idx    = 2'(q_cnt - 3'(pop));

        ovf_evt   = 1'b0;
        avail_nxt = avail_cnt;
        if (wr_tick && !BRAM_rd_en) begin
            if (avail_cnt == AVAIL_MAX) ovf_evt = 1'b1;
            else avail_nxt = avail_cnt + (ADDR_bw+1)'(1);
        end else if (!wr_tick && BRAM_rd_en) begin
            avail_nxt = avail_cnt - (ADDR_bw+1)'(1);
        end

        issue_nxt = rd_enable && (avail_nxt != '0) && ((q_cnt_nxt + fl_cnt_nxt) < 3'(QDEPTH));
    end

    always_ff @(posedge CLK) begin
        if (!RSTn || clr) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            BRAM_rd_addr <= '0;
            BRAM_rd_en   <= 1'b0;
            fl_vld       <= '0;
            fl_last      <= '0;
            q_cnt        <= '0;
            q_last       <= '0;
            for (int i = 0; i < QDEPTH; i++) q_data[i] <= '0;
            avail_cnt    <= '0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (rd_enable) state <= RUN;
                RUN:     if (!rd_enable) state <= DRAIN;
                DRAIN: begin
                    if (rd_enable) state <= RUN;
                    else if (fl_vld == '0 && !BRAM_rd_en && q_cnt == 3'd0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            BRAM_rd_en <= issue_nxt;
            if (issue_nxt) begin
                BRAM_rd_addr <= rd_ptr;
                rd_ptr       <= (rd_ptr == ADDR_LAST) ? '0 : rd_ptr + ADDR_bw'(1);
            end

            avail_cnt <= avail_nxt;
            if (ovf_evt) overflow <= 1'b1;

            fl_vld  <= fl_vld_nxt;
            fl_last <= fl_last_nxt;
            q_cnt   <= q_cnt_nxt;

            if (pop) begin
                for (int i = 0; i < QDEPTH-1; i++) begin
                    q_data[i] <= q_data[i+1];
                    q_last[i] <= q_last[i+1];
                end
                q_data[QDEPTH-1] <= '0;
                q_last[QDEPTH-1] <= 1'b0;
            end
            if (push) begin
                q_data[wr_idx] <= BRAM_rd_dout;
                q_last[wr_idx] <= fl_last[RD_LATENCY-1];
            end
        end
    end

endmodule

// File: tb/tb_rsa_result_reader.sv
// Testbench for rsa_result_reader: randomized result traffic against a BRAM model
// and an address-order scoreboard of the words expected on the output stream.
module tb_rsa_result_reader;
    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int NSLOT = 128;
    localparam int RL    = 2;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          wr_tick = 1'b0;
    logic          rd_enable = 1'b0;
    logic          clr = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] BRAM_rd_addr;
    logic          BRAM_rd_en;
    logic [DW-1:0] BRAM_rd_dout;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic [AW:0]   avail_cnt;
    logic          overflow;

    rsa_result_reader #(
        .ADDR_bw(AW), .BRAM_DATA_bw(DW), .MAX_DATA_NUM(NSLOT), .RD_LATENCY(RL)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .wr_tick(wr_tick), .rd_enable(rd_enable), .clr(clr),
        .BRAM_rd_addr(BRAM_rd_addr), .BRAM_rd_en(BRAM_rd_en), .BRAM_rd_dout(BRAM_rd_dout),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .avail_cnt(avail_cnt), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    // BRAM model: data valid RL cycles after the strobe, garbage otherwise
    logic [DW-1:0] mem [NSLOT];
    logic [DW-1:0] rd_pipe [RL];
    always @(posedge CLK) begin
        rd_pipe[0] <= BRAM_rd_en ? mem[BRAM_rd_addr[6:0]] : $urandom;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign BRAM_rd_dout = rd_pipe[RL-1];

    int            n_checks = 0;
    int            n_errors = 0;
    int            got, rd_seen, last_seen;
    int            exp_rd_addr, exp_out_addr, wr_ptr;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_data;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: reads in address order, words leave in address order
    always @(negedge CLK) begin
        if (RSTn && !clr) begin
            if (BRAM_rd_en) begin
                check_eq("rd_addr", 64'(BRAM_rd_addr), 64'(exp_rd_addr));
                exp_rd_addr = (exp_rd_addr + 1) % NSLOT;
                rd_seen++;
            end
            if (hold_prev) begin
                check_eq("hold_valid", 64'(out_valid), 64'(1));
                check_eq("hold_data", 64'(out_data), 64'(prev_data));
            end
            if (out_valid && out_ready) begin
                check_eq("out_data", 64'(out_data), 64'(mem[exp_out_addr]));
                check_eq("out_last", 64'(out_last), 64'(exp_out_addr == NSLOT-1));
                if (out_last) last_seen++;
                exp_out_addr = (exp_out_addr + 1) % NSLOT;
                got++;
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_model();
        got = 0; rd_seen = 0; last_seen = 0;
        exp_rd_addr = 0; exp_out_addr = 0; wr_ptr = 0;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        cyc();
        RSTn = 1'b1;
        reset_model();
    endtask

    task automatic tick(input logic [DW-1:0] v);
        wr_tick = 1'b1;
        mem[wr_ptr] = v;
        wr_ptr = (wr_ptr + 1) % NSLOT;
        cyc();
        wr_tick = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int k = 0; k < budget && got < n; k++) cyc();
        check_eq("word_count", 64'(got), 64'(n));
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge CLK);
        check_eq({tag, "_rd_en"}, 64'(BRAM_rd_en), 64'(0));
        check_eq({tag, "_rd_addr"}, 64'(BRAM_rd_addr), 64'(0));
        check_eq({tag, "_valid"}, 64'(out_valid), 64'(0));
        check_eq({tag, "_data"}, 64'(out_data), 64'(0));
        check_eq({tag, "_last"}, 64'(out_last), 64'(0));
        check_eq({tag, "_avail"}, 64'(avail_cnt), 64'(0));
        check_eq({tag, "_ovf"}, 64'(overflow), 64'(0));
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_model();
        cyc();
        do_reset();
        check_reset_outputs("reset");

        // single result: tick in c -> strobe c+1 -> out_valid c+4
        rd_enable = 1'b1; out_ready = 1'b1;
        cyc(); cyc();
        tick(32'hDEADBEEF);
        @(negedge CLK);
        check_eq("single_avail", 64'(avail_cnt), 64'(1));
        check_eq("single_rd_en", 64'(BRAM_rd_en), 64'(1));
        check_eq("single_addr", 64'(BRAM_rd_addr), 64'(0));
        cyc(); cyc();
        @(negedge CLK);
        check_eq("single_early_valid", 64'(out_valid), 64'(0));
        cyc();
        @(negedge CLK);
        check_eq("single_valid", 64'(out_valid), 64'(1));
        check_eq("single_data", 64'(out_data), 64'(32'hDEADBEEF));
        check_eq("single_last", 64'(out_last), 64'(0));
        check_eq("single_avail0", 64'(avail_cnt), 64'(0));
        cyc(); cyc();
        check_eq("single_words", 64'(got), 64'(1));

        // full frame with wrap, random data and tick spacing
        do_reset();
        for (int i = 0; i < 130; i++) begin
            tick($urandom);
            repeat ($urandom_range(0, 2)) cyc();
        end
        wait_words(130, 600);
        cyc(); cyc();
        check_eq("wrap_reads", 64'(rd_seen), 64'(130));
        check_eq("wrap_lasts", 64'(last_seen), 64'(1));
        check_eq("wrap_ovf", 64'(overflow), 64'(0));
        check_eq("wrap_avail", 64'(avail_cnt), 64'(0));

        // backpressure: at most 4 words reserved while out_ready is low
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick($urandom);
        repeat (10) cyc();
        @(negedge CLK);
        check_eq("bp_reads", 64'(rd_seen), 64'(4));
        check_eq("bp_valid", 64'(out_valid), 64'(1));
        check_eq("bp_head", 64'(out_data), 64'(mem[0]));
        cyc();
        for (int k = 0; k < 300 && got < 10; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        out_ready = 1'b1;
        wait_words(10, 50);
        cyc(); cyc();
        check_eq("bp_reads_all", 64'(rd_seen), 64'(10));
        check_eq("bp_words_all", 64'(got), 64'(10));
        check_eq("bp_avail", 64'(avail_cnt), 64'(0));

        // overflow: 129 ticks with reads disabled, oldest slot overwritten
        do_reset();
        rd_enable = 1'b0;
        for (int i = 0; i < 128; i++) tick($urandom);
        @(negedge CLK);
        check_eq("ovf_avail_full", 64'(avail_cnt), 64'(128));
        check_eq("ovf_not_yet", 64'(overflow), 64'(0));
        cyc();
        tick($urandom);
        @(negedge CLK);
        check_eq("ovf_avail_sat", 64'(avail_cnt), 64'(128));
        check_eq("ovf_flag", 64'(overflow), 64'(1));
        cyc();
        rd_enable = 1'b1;
        wait_words(128, 400);
        repeat (4) cyc();
        check_eq("ovf_reads", 64'(rd_seen), 64'(128));
        check_eq("ovf_words", 64'(got), 64'(128));
        check_eq("ovf_avail0", 64'(avail_cnt), 64'(0));
        check_eq("ovf_sticky", 64'(overflow), 64'(1));

        // drain: rd_enable drops in the cycle of the second strobe
        do_reset();
        rd_enable = 1'b0;
        repeat (5) tick($urandom);
        rd_enable = 1'b1;
        cyc(); cyc();
        rd_enable = 1'b0;
        repeat (12) cyc();
        @(negedge CLK);
        check_eq("drain_reads", 64'(rd_seen), 64'(2));
        check_eq("drain_words", 64'(got), 64'(2));
        check_eq("drain_valid", 64'(out_valid), 64'(0));
        check_eq("drain_rd_en", 64'(BRAM_rd_en), 64'(0));
        check_eq("drain_avail", 64'(avail_cnt), 64'(3));
        cyc();

        // mid-stream reset with words queued and one in flight
        do_reset();
        rd_enable = 1'b1; out_ready = 1'b0;
        repeat (3) tick($urandom);
        cyc(); cyc();
        RSTn = 1'b0;
        cyc();
        RSTn = 1'b1;
        reset_model();
        check_reset_outputs("midrst");
        cyc();
        out_ready = 1'b1;
        repeat (10) cyc();
        check_eq("midrst_words", 64'(got), 64'(0));
        check_eq("midrst_reads", 64'(rd_seen), 64'(0));

        // same with clr, plus a wr_tick in the clr cycle
        out_ready = 1'b0;
        repeat (3) tick($urandom);
        cyc(); cyc();
        clr = 1'b1; wr_tick = 1'b1;
        cyc();
        clr = 1'b0; wr_tick = 1'b0;
        reset_model();
        check_reset_outputs("clr");
        cyc();
        out_ready = 1'b1;
        repeat (10) cyc();
        check_eq("clr_words", 64'(got), 64'(0));
        tick($urandom);
        wait_words(1, 20);
        cyc(); cyc();
        check_eq("clr_reads", 64'(rd_seen), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
